// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN        : datapath width
//   FETCH_NOP   : bubble instruction (addi x0, x0, 0)
//   fetch_state_e : BOOT / RUN / HALT
//   fetch_pkt_t : registered fetch packet handed to decode
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] FETCH_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_four;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_pipe_reg.sv
// Output register between fetch and decode.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_flush        : drop the held packet (valid cleared, instr -> NOP)
//   i_load         : capture i_pkt as a new valid packet
//   i_pkt          : packet to capture
//   o_valid, o_pkt : registered packet presented to decode
// Flush wins over load. When neither is asserted the packet holds, which
// keeps the contents stable while decode stalls.
module fetch_pipe_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_flush,
  input  logic       i_load,
  input  fetch_pkt_t i_pkt,
  output logic       o_valid,
  output fetch_pkt_t o_pkt
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid       <= 1'b0;
      o_pkt.instr   <= NOP_INSTR;
      o_pkt.pc      <= RESET_PC;
      o_pkt.pc_four <= RESET_PC + 32'd4;
    end else if (i_flush) begin
      // pc fields are left as-is; only the instruction is scrubbed
      o_valid     <= 1'b0;
      o_pkt.instr <= NOP_INSTR;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_pkt   <= i_pkt;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, addresses IMEM, registers the fetched word into
// a valid/ready packet for decode, applies redirects and halts on bad PCs.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   o_imem_addr           : byte address to IMEM (the PC register)
//   i_imem_rdata          : combinational IMEM data for o_imem_addr
//   i_redirect_valid/_pc  : taken branch/jump and its target
//   i_ready               : decode accepts the packet
//   o_valid, o_instr, o_pc, o_pc_four : fetch packet
//   o_halted, o_misalign, o_oob       : sticky halt status
// Optional (macro FETCH_PERF_CNT_EN): o_fetch_cnt, o_flush_cnt saturating
// counters of handshakes and of redirects that killed a valid packet.
//
// state | meaning
// BOOT  | one bubble after reset, IMEM data ignored
// RUN   | sequential fetch, redirects, legality check
// HALT  | stopped on misaligned/out-of-range PC until reset
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_DEPTH = 2048,
  parameter logic [XLEN-1:0] NOP_INSTR  = FETCH_NOP
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four,
  output logic            o_halted,
  output logic            o_misalign,
  output logic            o_oob
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] o_fetch_cnt,
  output logic [XLEN-1:0] o_flush_cnt
`endif
);

  // Two extra bits so the limit is exact even for very large IMEM_DEPTH.
  localparam logic [XLEN+1:0] PC_LIMIT = (XLEN+2)'(IMEM_DEPTH) << 2;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            load_ok;
  logic            pc_misalign, pc_oob;
  logic            flush, capture;
  logic            set_misalign, set_oob;
  fetch_pkt_t      pkt_in, pkt_out;

  assign o_imem_addr = pc;
  assign load_ok     = !o_valid || i_ready;
  assign pc_misalign = (pc[1:0] != 2'b00);
  assign pc_oob      = ({2'b00, pc} >= PC_LIMIT);

  assign pkt_in.instr   = i_imem_rdata;
  assign pkt_in.pc      = pc;
  assign pkt_in.pc_four = pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      o_halted   <= 1'b0;
      o_misalign <= 1'b0;
      o_oob      <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (set_misalign) o_misalign <= 1'b1;
      if (set_oob)      o_oob      <= 1'b1;
      if (set_misalign || set_oob) o_halted <= 1'b1;
    end
  end

  // The legality check only acts when the output register could load, so a
  // packet held under stall is never replaced while decode still owns it.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    flush        = 1'b0;
    capture      = 1'b0;
    set_misalign = 1'b0;
    set_oob      = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        if (i_redirect_valid) begin
          pc_nxt = i_redirect_pc;
          flush  = 1'b1;
        end
      end
      RUN: begin
        if (i_redirect_valid) begin
          pc_nxt = i_redirect_pc;
          flush  = 1'b1;
        end else if (load_ok) begin
          if (pc_misalign) begin
            set_misalign = 1'b1;
            state_nxt    = HALT;
            flush        = 1'b1;
          end else if (pc_oob) begin
            set_oob   = 1'b1;
            state_nxt = HALT;
            flush     = 1'b1;
          end else begin
            capture = 1'b1;
            pc_nxt  = pc + 32'd4;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  fetch_pipe_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) u_pipe_reg (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_flush(flush),
    .i_load (capture),
    .i_pkt  (pkt_in),
    .o_valid(o_valid),
    .o_pkt  (pkt_out)
  );

  assign o_instr   = pkt_out.instr;
  assign o_pc      = pkt_out.pc;
  assign o_pc_four = pkt_out.pc_four;

`ifdef FETCH_PERF_CNT_EN
  logic handshake, flush_kill;
  assign handshake  = o_valid && i_ready;
  assign flush_kill = i_redirect_valid && o_valid && (state != HALT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fetch_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (handshake && (o_fetch_cnt != '1)) o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (flush_kill && (o_flush_cnt != '1)) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_instr, o_pc, o_pc_four;
  logic        o_halted, o_misalign, o_oob;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_flush_cnt;
`endif

  logic [31:0] mem [0:DEPTH-1];

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_boot, m_halt, m_valid, m_mis, m_oob;
  logic [31:0] m_pc, m_instr, m_opc;
  longint      m_fcnt, m_kcnt;

  always #5 i_clk = ~i_clk;

  assign i_imem_rdata = mem[o_imem_addr[AW+1:2]];

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .o_imem_addr     (o_imem_addr),
    .i_imem_rdata    (i_imem_rdata),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .i_ready         (i_ready),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .o_pc_four       (o_pc_four),
    .o_halted        (o_halted),
    .o_misalign      (o_misalign),
    .o_oob           (o_oob)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt     (o_fetch_cnt),
    .o_flush_cnt     (o_flush_cnt)
`endif
  );

  // One clock of the fetch stage as described behaviourally: what decode
  // should see after the edge, given the inputs held across it.
  task automatic model_step();
    if (i_reset) begin
      m_boot = 1; m_halt = 0; m_valid = 0; m_mis = 0; m_oob = 0;
      m_pc = 0; m_instr = NOP; m_opc = 0; m_fcnt = 0; m_kcnt = 0;
      return;
    end
    if (m_valid && i_ready && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
    if (i_redirect_valid && !m_halt && m_valid && m_kcnt < 64'hFFFF_FFFF) m_kcnt++;
    if (m_halt) return;
    if (m_boot) begin
      m_boot = 0;
      if (i_redirect_valid) m_pc = i_redirect_pc;
      return;
    end
    if (i_redirect_valid) begin
      m_pc = i_redirect_pc; m_valid = 0; m_instr = NOP;
    end else if (!m_valid || i_ready) begin
      if (m_pc % 4 != 0) begin
        m_mis = 1; m_halt = 1; m_valid = 0; m_instr = NOP;
      end else if (longint'(m_pc) >= 4 * DEPTH) begin
        m_oob = 1; m_halt = 1; m_valid = 0; m_instr = NOP;
      end else begin
        m_instr = mem[m_pc / 4]; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    i_reset = rst; i_redirect_valid = rv; i_redirect_pc = rpc; i_ready = rdy;
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 32'h100, 1);
    cyc(1, 0, 0, 0);
    checks++;
    if ({o_valid, o_halted, o_misalign, o_oob} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got v/h/m/o=%b%b%b%b want 0000", o_valid, o_halted, o_misalign, o_oob);
    end
    checks++;
    if (o_instr !== NOP || o_pc !== 32'h0 || o_pc_four !== 32'h4 || o_imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pkt: got instr=%h pc=%h pc4=%h addr=%h want %h 0 4 0", o_instr, o_pc, o_pc_four, o_imem_addr, NOP);
    end
  endtask

  task automatic test_basic();
    cyc(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL boot_bubble: got o_valid=%b want 0", o_valid);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h0050_0093 || o_pc_four !== 32'h4) begin
      errors++; $display("FAIL first_pkt: got v=%b pc=%h instr=%h pc4=%h want 1 0 00500093 4", o_valid, o_pc, o_instr, o_pc_four);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== 32'h00A0_0113) begin
      errors++; $display("FAIL second_pkt: got v=%b pc=%h instr=%h want 1 4 00a00113", o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_instr;
    exp_instr = mem[2];
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== exp_instr || o_imem_addr !== 32'hC) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h addr=%h want 1 8 %h c", i, o_valid, o_pc, o_instr, o_imem_addr, exp_instr);
      end
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (o_pc !== 32'hC || o_instr !== mem[3]) begin
      errors++; $display("FAIL stall_release: got pc=%h instr=%h want c %h", o_pc, o_instr, mem[3]);
    end
  endtask

  task automatic test_redirect();
    cyc(0, 1, 32'h40, 0);
    checks++;
    if (o_valid !== 1'b0 || o_instr !== NOP) begin
      errors++; $display("FAIL redirect_flush: got v=%b instr=%h want 0 %h", o_valid, o_instr, NOP);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== mem[16] || o_pc_four !== 32'h44) begin
      errors++; $display("FAIL redirect_target: got v=%b pc=%h instr=%h pc4=%h want 1 40 %h 44", o_valid, o_pc, o_instr, o_pc_four, mem[16]);
    end
  endtask

  task automatic test_misalign();
    cyc(0, 1, 32'h42, 1);
    cyc(0, 0, 0, 1);
    checks++;
    if ({o_misalign, o_halted, o_valid, o_oob} !== 4'b1100) begin
      errors++; $display("FAIL misalign_halt: got m/h/v/o=%b%b%b%b want 1100", o_misalign, o_halted, o_valid, o_oob);
    end
    cyc(0, 1, 32'h100, 1);
    cyc(0, 0, 0, 1);
    checks++;
    if (o_halted !== 1'b1 || o_valid !== 1'b0 || o_imem_addr !== 32'h42) begin
      errors++; $display("FAIL halt_ignores_redirect: got h=%b v=%b addr=%h want 1 0 42", o_halted, o_valid, o_imem_addr);
    end
    cyc(1, 0, 0, 1);
    checks++;
    if ({o_misalign, o_halted, o_oob} !== 3'b000 || o_imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_clears_halt: got m/h/o=%b%b%b addr=%h want 000 0", o_misalign, o_halted, o_oob, o_imem_addr);
    end
  endtask

  task automatic test_oob();
    logic [31:0] base;
    base = 4 * DEPTH - 8;
    cyc(0, 0, 0, 1);
    cyc(0, 1, base, 1);
    cyc(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== base) begin
      errors++; $display("FAIL oob_last_minus1: got v=%b pc=%h want 1 %h", o_valid, o_pc, base);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== base + 4 || o_instr !== mem[DEPTH-1]) begin
      errors++; $display("FAIL oob_last_word: got v=%b pc=%h instr=%h want 1 %h %h", o_valid, o_pc, o_instr, base + 4, mem[DEPTH-1]);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if ({o_oob, o_halted, o_valid, o_misalign} !== 4'b1100 || o_imem_addr !== 4 * DEPTH) begin
      errors++; $display("FAIL oob_halt: got o/h/v/m=%b%b%b%b addr=%h want 1100 %h", o_oob, o_halted, o_valid, o_misalign, o_imem_addr, 4 * DEPTH);
    end
  endtask

  task automatic test_random();
    bit          rst, rv, rdy;
    logic [31:0] rpc;
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = {19'd0, 11'($urandom_range(0, DEPTH - 1)), 2'b00};
      if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) rpc = 4 * DEPTH + 4 * $urandom_range(0, 3);
      cyc(rst, rv, rpc, rdy);
      checks++;
      if ({o_valid, o_halted, o_misalign, o_oob} !== {m_valid, m_halt, m_mis, m_oob} ||
          o_instr !== m_instr || o_pc !== m_opc || o_pc_four !== m_opc + 32'd4 ||
          o_imem_addr !== m_pc) begin
        errors++;
        $display("FAIL random[%0d]: got v/h/m/o=%b%b%b%b instr=%h pc=%h pc4=%h addr=%h want %b%b%b%b %h %h %h %h",
                 n, o_valid, o_halted, o_misalign, o_oob, o_instr, o_pc, o_pc_four, o_imem_addr,
                 m_valid, m_halt, m_mis, m_oob, m_instr, m_opc, m_opc + 32'd4, m_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (o_fetch_cnt !== 32'(m_fcnt) || o_flush_cnt !== 32'(m_kcnt)) begin
        errors++; $display("FAIL random_cnt[%0d]: got f=%0d k=%0d want %0d %0d", n, o_fetch_cnt, o_flush_cnt, m_fcnt, m_kcnt);
      end
`endif
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    cyc(1, 0, 0, 0);
    checks++;
    if (o_fetch_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got f=%0d k=%0d want 0 0", o_fetch_cnt, o_flush_cnt);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h20, 0);
    checks++;
    if (o_fetch_cnt !== 32'd5 || o_flush_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_counts: got f=%0d k=%0d want 5 1", o_fetch_cnt, o_flush_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_misalign();
    test_oob();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
